// File: rtl/serial_tx_package_queue_pkg.sv
// Shared serial-link definitions: frame line levels and transmitter FSM encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_tx_package_queue_pkg;

  // Line levels shared with the receiving end of the link.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_tx_package_queue_if.sv
// Queue-side bundle of the package transmitter: push/full handshake, status and serial line.
// Latency: none (wiring only).
// Backpressure: producer must hold off while full_o is high; pushes made while full are dropped.
interface serial_tx_package_queue_if #(
  parameter int AddressWidth = 2,
  parameter int WordWidth    = 8
);
  localparam int PackageWidth = (2**AddressWidth) * WordWidth;

  logic                    push_i;
  logic [PackageWidth-1:0] d_i;
  logic                    tx_o;
  logic                    void_o;
  logic                    full_o;
  logic                    busy_o;

  // Package producer side.
  modport master (output push_i, d_i, input tx_o, void_o, full_o, busy_o);
  // Transmitter side.
  modport slave  (input push_i, d_i, output tx_o, void_o, full_o, busy_o);
endinterface

// File: rtl/serial_tx_package_queue_package_fifo.sv
// Circular package buffer with push/pop and void/full flags, reusable by the receiver.
// Latency: a push is visible on q_o/void_o one edge later; flags are registered-pointer compares.
// Backpressure: push while full and pop while void are ignored; full is sampled before a same-cycle pop.
module package_fifo #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DataWidth-1:0] d_i,
  output logic [DataWidth-1:0] q_o,
  output logic                 void_o,
  output logic                 full_o
);

  logic [AddrWidth:0]   wr_q, wr_d;
  logic [AddrWidth:0]   rd_q, rd_d;
  logic [DataWidth-1:0] mem_q [2**AddrWidth];
  logic                 wr_en, rd_en;

  // Pointers carry one extra wrap bit so equal-index cases split into empty and full.
  assign void_o = (wr_q == rd_q);
  assign full_o = ((wr_q ^ rd_q) == {1'b1, {AddrWidth{1'b0}}});
  assign wr_en  = push_i & ~full_o;
  assign rd_en  = pop_i & ~void_o;
  assign q_o    = mem_q[rd_q[AddrWidth-1:0]];

  // Pointer advance for accepted push and pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + 1'b1;
    if (rd_en) rd_d = rd_q + 1'b1;
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AddrWidth-1:0]] <= d_i;
  end

endmodule

// File: rtl/serial_tx_package_queue.sv
// Queued package transmitter: buffers whole packages and sends each word as a start/data/stop frame.
// Latency: first start bit two edges after the push; word frame (WordWidth+2)*2**SerialTimerWidth clocks.
// Backpressure: full_o high drops new pushes; a slot frees on the edge a package is loaded for sending.
module serial_tx_package_queue
  import serial_tx_package_queue_pkg::*;
#(
  parameter int AddressWidth      = 2,
  parameter int WordWidth         = 8,
  parameter int SerialTimerWidth  = 3,
  parameter int QueueAddressWidth = 2
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  serial_tx_package_queue_if.slave bus
);

  localparam int PackageWidth = (2**AddressWidth) * WordWidth;
  localparam int BitCntWidth  = $clog2(WordWidth);

  state_t                      state_q, state_d;
  logic [SerialTimerWidth-1:0] timer_q, timer_d;
  logic [BitCntWidth-1:0]      bit_q, bit_d;
  logic [AddressWidth-1:0]     word_q, word_d;
  logic [PackageWidth-1:0]     shift_q, shift_d;
  logic                        tx_q, tx_d;
  logic                        pop;
  logic                        bit_end;
  logic [PackageWidth-1:0]     head;
  logic                        q_void, q_full;

  package_fifo #(
    .DataWidth (PackageWidth),
    .AddrWidth (QueueAddressWidth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (bus.push_i),
    .pop_i  (pop),
    .d_i    (bus.d_i),
    .q_o    (head),
    .void_o (q_void),
    .full_o (q_full)
  );

  assign bit_end     = (timer_q == '1);
  assign bus.tx_o    = tx_q;
  assign bus.void_o  = q_void;
  assign bus.full_o  = q_full;
  assign bus.busy_o  = ~q_void | (state_q != ST_IDLE);

  // Frame sequencing: timer, bit/word counters, shift register, queue pop and next line level.
  always_comb begin
    state_d = state_q;
    timer_d = (state_q == ST_IDLE) ? '0 : timer_q + 1'b1;
    bit_d   = bit_q;
    word_d  = word_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!q_void) begin
          shift_d = head;
          pop     = 1'b1;
          word_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          // Only the current word shifts per bit; the whole package moves by a word at STOP.
          shift_d = {shift_q[PackageWidth-1:WordWidth], shift_q[WordWidth-1:0] >> 1};
          if (bit_q == BitCntWidth'(WordWidth-1)) state_d = ST_STOP;
          else                                     bit_d   = bit_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (word_q != '1) begin
            word_d  = word_q + 1'b1;
            shift_d = shift_q >> WordWidth;
            state_d = ST_START;
          end else if (!q_void) begin
            // Back-to-back: the next package starts with no idle bit.
            shift_d = head;
            pop     = 1'b1;
            word_d  = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = STOP_BIT;
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drives the line idle at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
